// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite image ROM arbiter.
//   NUM_REQ_DEF    default requester count
//   SPRITE_ADDR_W  image BRAM address width (256x256 texels)
//   PALETTE_IDX_W  image BRAM data width (palette index)
//   RD_LATENCY_DEF default BRAM read latency (HIGH_PERFORMANCE output register)
package sprite_pkg;

  localparam int unsigned NUM_REQ_DEF    = 4;
  localparam int unsigned SPRITE_ADDR_W  = $clog2(256 * 256);
  localparam int unsigned PALETTE_IDX_W  = 8;
  localparam int unsigned RD_LATENCY_DEF = 2;

  typedef logic [$clog2(NUM_REQ_DEF)-1:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/sprite_rom_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     per-requester request vector
//   en      grant enable; no grant when low
//   ptr     highest-priority index for this cycle
//   gnt     one-hot grant (or zero)
//   gnt_idx index of the granted requester (0 when no grant)
//   gnt_any high when any grant is made
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic                 en,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_any
);

  localparam int unsigned IW = $clog2(N);

  always_comb begin
    int unsigned idx;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    if (en) begin
      // Cyclic scan starting at ptr; the first valid index wins.
      for (int unsigned k = 0; k < N; k++) begin
        idx = (32'(ptr) + k) % N;
        if (!gnt_any && req[idx]) begin
          gnt[idx] = 1'b1;
          gnt_idx  = IW'(idx);
          gnt_any  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one single-port sprite image BRAM among NUM_REQ sprite pipelines.
// One round-robin grant per cycle; the requester ID rides a RD_LATENCY-deep
// tag pipeline so read data is steered back to its owner.
//   pixel_clk_in   clock (rising edge)
//   rst_n_in       asynchronous active-low reset
//   stall_in       suppresses new grants (in-flight reads still return)
//   req_valid_in   per-requester read request
//   req_addr_in    per-requester address, packed NUM_REQ x ADDR_W
//   req_ready_out  one-hot grant, combinational
//   rom_addr_out   BRAM addra (granted address, else last granted address)
//   rom_en_out     BRAM ena, high only in a grant cycle
//   rom_data_in    BRAM douta
//   rsp_valid_out  one-hot owner of the returning data
//   rsp_data_out   returning data, qualified by rsp_valid_out
//   rsp_id_out     index of the returning owner, 0 when idle
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
  parameter int unsigned ADDR_W     = SPRITE_ADDR_W,
  parameter int unsigned DATA_W     = PALETTE_IDX_W,
  parameter int unsigned RD_LATENCY = RD_LATENCY_DEF
) (
  input  logic                        pixel_clk_in,
  input  logic                        rst_n_in,
  input  logic                        stall_in,
  input  logic [NUM_REQ-1:0]          req_valid_in,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_in,
  output logic [NUM_REQ-1:0]          req_ready_out,
  output logic [ADDR_W-1:0]           rom_addr_out,
  output logic                        rom_en_out,
  input  logic [DATA_W-1:0]           rom_data_in,
  output logic [NUM_REQ-1:0]          rsp_valid_out,
  output logic [DATA_W-1:0]           rsp_data_out,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id_out
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]       ptr;
  logic [ID_W-1:0]       ptr_next;
  logic [NUM_REQ-1:0]    gnt;
  logic [ID_W-1:0]       gnt_idx;
  logic                  gnt_any;
  logic                  arb_en;
  logic [ADDR_W-1:0]     gnt_addr;
  logic [ADDR_W-1:0]     last_addr;
  logic [RD_LATENCY-1:0] tag_valid;
  logic [ID_W-1:0]       tag_id [RD_LATENCY];

  // Gating with reset keeps every output at its reset value while reset is low,
  // even if requesters keep valid asserted.
  assign arb_en = ~stall_in & rst_n_in;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .req     (req_valid_in),
    .en      (arb_en),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign req_ready_out = gnt;
  assign rom_en_out    = gnt_any;
  assign rsp_data_out  = rom_data_in;

  // AND-OR mux on the one-hot grant avoids a variable-index part select.
  always_comb begin
    gnt_addr = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_addr = req_addr_in[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign rom_addr_out = gnt_any ? gnt_addr : last_addr;

  always_comb begin
    ptr_next = gnt_idx + 1'b1;
    if (gnt_idx == ID_W'(NUM_REQ - 1)) begin
      ptr_next = '0;
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ptr       <= '0;
      last_addr <= '0;
      tag_valid <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        tag_id[i] <= '0;
      end
    end else begin
      if (gnt_any) begin
        ptr       <= ptr_next;
        last_addr <= gnt_addr;
      end
      tag_valid[0] <= gnt_any;
      tag_id[0]    <= gnt_idx;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
    end
  end

  always_comb begin
    rsp_valid_out = '0;
    rsp_id_out    = '0;
    if (tag_valid[RD_LATENCY-1]) begin
      rsp_valid_out[tag_id[RD_LATENCY-1]] = 1'b1;
      rsp_id_out                          = tag_id[RD_LATENCY-1];
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: a 4-requester / latency-2 instance driven from a
// vector table plus a reset-in-flight sequence, and a 2-requester / latency-1
// instance for alternation and latency. Responses are scoreboarded.
module tb_sprite_rom_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic stall;
  always #10 clk = ~clk;

  // 4-requester, latency 2
  logic [3:0]  valid_a, ready_a, rsp_valid_a;
  logic [63:0] addr_a;
  logic [15:0] rom_addr_a;
  logic        en_a;
  logic [7:0]  rom_data_a, rsp_data_a, ma1, ma2;
  logic [1:0]  rsp_id_a;

  // 2-requester, latency 1
  logic [1:0]  valid_b, ready_b, rsp_valid_b;
  logic [31:0] addr_b;
  logic [15:0] rom_addr_b;
  logic        en_b;
  logic [7:0]  rom_data_b, rsp_data_b, mb1;
  logic        rsp_id_b;

  sprite_rom_arbiter #(
    .NUM_REQ(4), .ADDR_W(16), .DATA_W(8), .RD_LATENCY(2)
  ) dut_a (
    .pixel_clk_in (clk),        .rst_n_in     (rst_n),
    .stall_in     (stall),      .req_valid_in (valid_a),
    .req_addr_in  (addr_a),     .req_ready_out(ready_a),
    .rom_addr_out (rom_addr_a), .rom_en_out   (en_a),
    .rom_data_in  (rom_data_a), .rsp_valid_out(rsp_valid_a),
    .rsp_data_out (rsp_data_a), .rsp_id_out   (rsp_id_a)
  );

  sprite_rom_arbiter #(
    .NUM_REQ(2), .ADDR_W(16), .DATA_W(8), .RD_LATENCY(1)
  ) dut_b (
    .pixel_clk_in (clk),        .rst_n_in     (rst_n),
    .stall_in     (1'b0),       .req_valid_in (valid_b),
    .req_addr_in  (addr_b),     .req_ready_out(ready_b),
    .rom_addr_out (rom_addr_b), .rom_en_out   (en_b),
    .rom_data_in  (rom_data_b), .rsp_valid_out(rsp_valid_b),
    .rsp_data_out (rsp_data_b), .rsp_id_out   (rsp_id_b)
  );

  function automatic logic [7:0] memf(input logic [15:0] a);
    return a[7:0] + (a[15:8] * 8'd3) + 8'h5A;
  endfunction

  // BRAM models: latency 2 (input + output register) and latency 1.
  always @(posedge clk) begin
    if (en_a) ma1 <= memf(rom_addr_a);
    ma2 <= ma1;
    if (en_b) mb1 <= memf(rom_addr_b);
  end
  assign rom_data_a = ma2;
  assign rom_data_b = mb1;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned npass = 0;
  int unsigned ntot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    int unsigned due;
    int unsigned id;
    logic [7:0]  data;
  } rsp_t;

  rsp_t qa[$];
  rsp_t qb[$];

  always @(negedge clk) begin : chk_rsp_a
    rsp_t e;
    if (qa.size() != 0 && qa[0].due == cyc) begin
      e = qa.pop_front();
      chk("rsp_valid_a", 32'(rsp_valid_a), 32'(1) << e.id);
      chk("rsp_id_a", 32'(rsp_id_a), e.id);
      chk("rsp_data_a", 32'(rsp_data_a), 32'(e.data));
    end else begin
      chk("rsp_idle_a", {26'd0, rsp_valid_a, rsp_id_a}, 32'd0);
    end
  end

  always @(negedge clk) begin : chk_rsp_b
    rsp_t e;
    if (qb.size() != 0 && qb[0].due == cyc) begin
      e = qb.pop_front();
      chk("rsp_valid_b", 32'(rsp_valid_b), 32'(1) << e.id);
      chk("rsp_id_b", 32'(rsp_id_b), e.id);
      chk("rsp_data_b", 32'(rsp_data_b), 32'(e.data));
    end else begin
      chk("rsp_idle_b", {29'd0, rsp_valid_b, rsp_id_b}, 32'd0);
    end
  end

  typedef struct {
    logic [3:0]  valid;
    logic        stall;
    logic [63:0] addrs;
    logic [3:0]  exp;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] exp_last_a = '0;

  function automatic logic [63:0] mk(input logic [15:0] a0, input logic [15:0] a1,
                                     input logic [15:0] a2, input logic [15:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic step_a(input string tag, input logic [3:0] v, input logic s,
                        input logic [63:0] a, input logic [3:0] e);
    int unsigned gi;
    logic [15:0] ga;
    valid_a = v;
    stall   = s;
    addr_a  = a;
    @(negedge clk);
    chk({tag, " ready"}, 32'(ready_a), 32'(e));
    chk({tag, " rom_en"}, 32'(en_a), 32'(e != 4'd0));
    if (e != 4'd0) begin
      gi = 0;
      for (int unsigned i = 0; i < 4; i++) if (e[i]) gi = i;
      ga = a[gi*16 +: 16];
      exp_last_a = ga;
      qa.push_back('{cyc + 2, gi, memf(ga)});
    end
    chk({tag, " rom_addr"}, 32'(rom_addr_a), 32'(exp_last_a));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] base;
    rst_n   = 1'b0;
    stall   = 1'b0;
    valid_a = '0;
    addr_a  = '0;
    valid_b = '0;
    addr_b  = '0;
    repeat (3) @(posedge clk);
    #1;
    valid_a = 4'hF;
    valid_b = 2'b11;
    #1;
    chk("reset ready_a", 32'(ready_a), 32'd0);
    chk("reset rom_en_a", 32'(en_a), 32'd0);
    chk("reset rom_addr_a", 32'(rom_addr_a), 32'd0);
    chk("reset ready_b", 32'(ready_b), 32'd0);
    valid_a = '0;
    valid_b = '0;
    rst_n   = 1'b1;
    @(posedge clk);
    #1;

    base = mk(16'h0000, 16'h0100, 16'h0200, 16'h0300);
    // All four valid: plain rotation.
    for (int i = 0; i < 8; i++) vecs.push_back('{4'hF, 1'b0, base, 4'(1 << (i % 4))});
    // Lone requester 2 streaming addresses 0..5.
    for (int k = 0; k < 6; k++)
      vecs.push_back('{4'b0100, 1'b0, mk(16'h0, 16'h0, 16'(k), 16'h0), 4'b0100});
    // ptr=3: grant 3, then 0/3 contend.
    vecs.push_back('{4'b1000, 1'b0, base, 4'b1000});
    vecs.push_back('{4'b1001, 1'b0, base, 4'b0001});
    vecs.push_back('{4'b1001, 1'b0, base, 4'b1000});
    // ptr=3 with only 0/1 valid: search wraps to 0.
    vecs.push_back('{4'b0100, 1'b0, base, 4'b0100});
    vecs.push_back('{4'b0011, 1'b0, base, 4'b0001});
    vecs.push_back('{4'b0010, 1'b0, base, 4'b0010});
    // Idle: address register holds last grant.
    vecs.push_back('{4'b0000, 1'b0, base, 4'b0000});
    vecs.push_back('{4'b1000, 1'b0, base, 4'b1000});
    // Stall with 1 and 3 valid, then release at ptr=0.
    for (int i = 0; i < 3; i++) vecs.push_back('{4'b1010, 1'b1, base, 4'b0000});
    vecs.push_back('{4'b1010, 1'b0, base, 4'b0010});
    vecs.push_back('{4'b1010, 1'b0, base, 4'b1000});

    for (int i = 0; i < vecs.size(); i++)
      step_a($sformatf("vec%0d", i), vecs[i].valid, vecs[i].stall, vecs[i].addrs, vecs[i].exp);
    repeat (3) step_a("drain", 4'b0000, 1'b0, base, 4'b0000);

    // Grants to 0 then 1, reset pulsed before the second grant is captured.
    valid_a = 4'b0001;
    @(negedge clk);
    chk("rst_seq gnt0", 32'(ready_a), 32'b0001);
    @(posedge clk);
    #1;
    valid_a = 4'b0010;
    @(negedge clk);
    chk("rst_seq gnt1", 32'(ready_a), 32'b0010);
    #1;
    rst_n = 1'b0;
    #1;
    chk("in_rst ready", 32'(ready_a), 32'd0);
    chk("in_rst rom_en", 32'(en_a), 32'd0);
    chk("in_rst rom_addr", 32'(rom_addr_a), 32'd0);
    chk("in_rst rsp", {26'd0, rsp_valid_a, rsp_id_a}, 32'd0);
    @(posedge clk);
    #1;
    chk("in_rst ready edge", 32'(ready_a), 32'd0);
    chk("in_rst rsp edge", {26'd0, rsp_valid_a, rsp_id_a}, 32'd0);
    rst_n      = 1'b1;
    exp_last_a = '0;
    step_a("post_rst", 4'b0011, 1'b0, base, 4'b0001);
    step_a("post_rst2", 4'b0011, 1'b0, base, 4'b0010);
    repeat (4) step_a("drain2", 4'b0000, 1'b0, base, 4'b0000);

    // Two requesters, latency 1: strict alternation.
    addr_b = {16'h0222, 16'h0111};
    for (int k = 0; k < 6; k++) begin
      valid_b = 2'b11;
      @(negedge clk);
      chk($sformatf("b%0d ready", k), 32'(ready_b), (k % 2 == 0) ? 32'b01 : 32'b10);
      chk($sformatf("b%0d rom_en", k), 32'(en_b), 32'd1);
      chk($sformatf("b%0d rom_addr", k), 32'(rom_addr_b), (k % 2 == 0) ? 32'h0111 : 32'h0222);
      qb.push_back('{cyc + 1, k % 2, memf((k % 2 == 0) ? 16'h0111 : 16'h0222)});
      @(posedge clk);
      #1;
    end
    valid_b = '0;
    repeat (3) @(posedge clk);
    #1;

    chk("sb_drain_a", 32'(qa.size()), 32'd0);
    chk("sb_drain_b", 32'(qb.size()), 32'd0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
